// File: rtl/seq_mult_unit.sv
// Iterative shift-add multiplier for MULT/MULTU: one multiplier bit per cycle,
// sign handled by magnitude multiply plus a final conditional negation.
module seq_mult_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mult_q, mult_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   mag_a_c, mag_b_c;
    logic [WIDTH:0]     sum_c;
    logic [PW-1:0]      prod_raw_c, prod_c;

    // Magnitudes stay unsigned so the most negative operand maps to 2^(WIDTH-1).
    always_comb begin
        mag_a_c    = (is_signed && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
        mag_b_c    = (is_signed && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
        sum_c      = acc_q + {1'b0, mcand_q & {WIDTH{mult_q[0]}}};
        prod_raw_c = {acc_q[WIDTH-1:0], mult_q};
        prod_c     = neg_q ? (~prod_raw_c + PW'(1)) : prod_raw_c;
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    mcand_d = mag_a_c;
                    mult_d  = mag_b_c;
                    neg_d   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d  = {1'b0, sum_c[WIDTH:1]};
                    mult_d = {sum_c[0], mult_q[WIDTH-1:1]};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (!flush) begin
                    hi_d   = prod_c[PW-1:WIDTH];
                    lo_d   = prod_c[WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            mult_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
